// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2**N one-hot decoder with DIRECT (valid/ready index) and SCAN (auto-step with dwell) modes.
// Optional build macro DECODER_ACTIVE_LOW_EN inverts dout (reset and disabled value become all ones).
module decoder_nto2n_seq #(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8,
  parameter int DWELL   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic               en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   din,
  output logic [NUM_OUT-1:0] dout,
  output logic               dout_valid,
  output logic [SEL_W-1:0]   sel_cur,
  output logic               err
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NUM_OUT - 1);
  localparam logic [SEL_W:0]   NUM_OUT_X  = (SEL_W + 1)'(NUM_OUT);

  function automatic logic [NUM_OUT-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot = NUM_OUT'(1) << idx;
  endfunction

  logic              mode_p0;
  logic              code_ok;
  logic [DW_W-1:0]   dwell_cnt;
  logic [NUM_OUT-1:0] dout_p0;

  logic [SEL_W-1:0]  sel_nxt;
  logic [DW_W-1:0]   dwell_nxt;
  logic              code_ok_nxt;
  logic              err_nxt;
  logic [NUM_OUT-1:0] dout_nxt;

  assign in_ready = ~mode;

  always_comb begin
    sel_nxt     = sel_cur;
    dwell_nxt   = dwell_cnt;
    code_ok_nxt = code_ok;
    err_nxt     = 1'b0;
    if (mode && !mode_p0) begin
      // Scan entry restarts at output 0; a din offered this cycle is not accepted.
      sel_nxt     = '0;
      dwell_nxt   = '0;
      code_ok_nxt = 1'b1;
    end else if (mode) begin
      if (en) begin
        if (dwell_cnt == DWELL_LAST) begin
          dwell_nxt = '0;
          sel_nxt   = (sel_cur == SEL_LAST) ? '0 : sel_cur + SEL_W'(1);
        end else begin
          dwell_nxt = dwell_cnt + DW_W'(1);
        end
      end
    end else if (in_valid) begin
      if ({1'b0, din} < NUM_OUT_X) begin
        sel_nxt     = din;
        code_ok_nxt = 1'b1;
      end else begin
        code_ok_nxt = 1'b0;
        err_nxt     = 1'b1;
      end
    end
    dout_nxt = (en && code_ok_nxt) ? onehot(sel_nxt) : '0;
  end

  // Stage p0: all state and outputs registered together
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_p0    <= 1'b0;
      code_ok    <= 1'b0;
      dwell_cnt  <= '0;
      sel_cur    <= '0;
      err        <= 1'b0;
      dout_valid <= 1'b0;
      dout_p0    <= '0;
    end else begin
      mode_p0    <= mode;
      code_ok    <= code_ok_nxt;
      dwell_cnt  <= dwell_nxt;
      sel_cur    <= sel_nxt;
      err        <= err_nxt;
      dout_valid <= en & code_ok_nxt;
      dout_p0    <= dout_nxt;
    end
  end

`ifdef DECODER_ACTIVE_LOW_EN
  assign dout = ~dout_p0;
`else
  assign dout = dout_p0;
`endif

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Directed bench for decoder_nto2n_seq: an 8-output and a 6-output instance share one stimulus.
// Honors DECODER_ACTIVE_LOW_EN by inverting expected dout values.
module tb_decoder_nto2n_seq;

  logic clk = 1'b0;
  logic rst, mode, en, in_valid;
  logic [2:0] din;

  logic       rdy8, dv8, err8;
  logic [7:0] dout8;
  logic [2:0] sel8;
  logic       rdy6, dv6, err6;
  logic [5:0] dout6;
  logic [2:0] sel6;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decoder_nto2n_seq #(.SEL_W(3), .NUM_OUT(8), .DWELL(4)) u8 (
    .clk(clk), .rst(rst), .mode(mode), .en(en), .in_valid(in_valid), .in_ready(rdy8),
    .din(din), .dout(dout8), .dout_valid(dv8), .sel_cur(sel8), .err(err8)
  );

  decoder_nto2n_seq #(.SEL_W(3), .NUM_OUT(6), .DWELL(4)) u6 (
    .clk(clk), .rst(rst), .mode(mode), .en(en), .in_valid(in_valid), .in_ready(rdy6),
    .din(din), .dout(dout6), .dout_valid(dv6), .sel_cur(sel6), .err(err6)
  );

  function automatic logic [7:0] e8(input logic [7:0] x);
`ifdef DECODER_ACTIVE_LOW_EN
    e8 = ~x;
`else
    e8 = x;
`endif
  endfunction

  function automatic logic [5:0] e6(input logic [5:0] x);
`ifdef DECODER_ACTIVE_LOW_EN
    e6 = ~x;
`else
    e6 = x;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] x8;
    logic [5:0] x6;
    rst = 1'b1; mode = 1'b0; en = 1'b0; in_valid = 1'b0; din = 3'd0;
    step(); step();
    chk("rst_dout8", dout8, e8(8'h00));
    chk("rst_dv8",   dv8,   0);
    chk("rst_sel8",  sel8,  0);
    chk("rst_err8",  err8,  0);
    chk("rst_dout6", dout6, e6(6'h00));

    // DIRECT decode of 5
    rst = 1'b0; en = 1'b1; in_valid = 1'b1; din = 3'd5;
    chk("rdy_direct", rdy8, 1);
    step();
    chk("d5_dout8", dout8, e8(8'h20));
    chk("d5_dv8",   dv8,   1);
    chk("d5_sel8",  sel8,  5);
    chk("d5_dout6", dout6, e6(6'h20));
    in_valid = 1'b0; din = 3'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("d5_hold", dout8, e8(8'h20));
    end

    // Out-of-range index on the 6-output instance
    in_valid = 1'b1; din = 3'd7;
    step();
    chk("oor_err6",  err6,  1);
    chk("oor_dout6", dout6, e6(6'h00));
    chk("oor_dv6",   dv6,   0);
    chk("oor_sel6",  sel6,  5);
    chk("d7_dout8",  dout8, e8(8'h80));
    chk("d7_err8",   err8,  0);
    in_valid = 1'b0;
    step();
    chk("oor_err6_pulse", err6, 0);
    chk("oor_dout6_hold", dout6, e6(6'h00));

    // en gating in DIRECT
    en = 1'b0;
    step();
    chk("en0_dout8", dout8, e8(8'h00));
    chk("en0_dv8",   dv8,   0);
    en = 1'b1;
    step();
    chk("en1_dout8", dout8, e8(8'h80));

    in_valid = 1'b1; din = 3'd0;
    step();
    chk("d0_dout8", dout8, e8(8'h01));

    // SCAN entry with simultaneous in_valid: din=3 must be ignored
    mode = 1'b1; in_valid = 1'b1; din = 3'd3;
    #0;
    chk("rdy_scan", rdy8, 0);
    step();
    in_valid = 1'b0;
    chk("scan_entry_sel", sel8, 0);
    for (int k = 0; k < 38; k++) begin
      if (k > 0) step();
      x8 = 8'h01 << ((k / 4) % 8);
      x6 = 6'h01 << ((k / 4) % 6);
      chk($sformatf("scan8_%0d", k), dout8, e8(x8));
      chk($sformatf("scan6_%0d", k), dout6, e6(x6));
    end

    // en gap mid-dwell (two cycles of output 1 already shown)
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("gap_dout8", dout8, e8(8'h00));
      chk("gap_dv8",   dv8,   0);
    end
    en = 1'b1;
    step(); chk("resume_a", dout8, e8(8'h02));
    step(); chk("resume_b", dout8, e8(8'h02));
    step(); chk("resume_c", dout8, e8(8'h04));
    chk("resume_c6", dout6, e6(6'h10));

    for (int i = 0; i < 16; i++) step();
    chk("pre_rst_sel8",  sel8,  6);
    chk("pre_rst_dout8", dout8, e8(8'h40));

    // Reset mid-scan
    rst = 1'b1;
    step();
    chk("mrst_dout8", dout8, e8(8'h00));
    chk("mrst_dv8",   dv8,   0);
    chk("mrst_sel8",  sel8,  0);
    chk("mrst_err8",  err8,  0);

    // Re-enter scan, advance to output 1, then leave scan
    rst = 1'b0; mode = 1'b0;
    step();
    mode = 1'b1;
    step();
    chk("reent_dout8", dout8, e8(8'h01));
    for (int i = 0; i < 4; i++) step();
    chk("reent_adv", dout8, e8(8'h02));
    mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("leave_dout8", dout8, e8(8'h02));
      chk("leave_sel8",  sel8,  1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
